nbit_seq_shifter: RTL

//  Parametrised iterative shifter: successor to the single-bit shift-left block.

---
 rtl/nbit_seq_shifter.sv | 101 ++++++++++
 1 files changed

// File: rtl/nbit_seq_shifter.sv
// Iterative N-bit shifter: one bit position per clock for SLL/SRL/SRA/ROL,
// with valid/ready handshakes on both the operand and the result side.
module nbit_seq_shifter #(
    parameter  int N   = 32,
    localparam int SHW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_data,
    input  logic [SHW-1:0] in_shamt,
    input  logic [1:0]     in_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_data,
    output logic           busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;

    state_t         r_state;
    logic [N-1:0]   r_data;
    logic [1:0]     r_mode;
    logic [SHW-1:0] r_count;

    state_t         w_state_next;
    logic [N-1:0]   w_data_next;
    logic [1:0]     w_mode_next;
    logic [SHW-1:0] w_count_next;
    logic [N-1:0]   w_shift1;
    logic           w_accept;

    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_SHIFT);
    assign out_data  = r_data;

    // Single-position step of the working register for the latched mode.
    always_comb begin
        w_shift1 = {r_data[N-2:0], r_data[N-1]};
        case (r_mode)
            MODE_SLL: w_shift1 = {r_data[N-2:0], 1'b0};
            MODE_SRL: w_shift1 = {1'b0, r_data[N-1:1]};
            MODE_SRA: w_shift1 = {r_data[N-1], r_data[N-1:1]};
            default:  w_shift1 = {r_data[N-2:0], r_data[N-1]};
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_data_next  = r_data;
        w_mode_next  = r_mode;
        w_count_next = r_count;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_data_next  = in_data;
                    w_mode_next  = in_mode;
                    w_count_next = in_shamt;
                    w_state_next = (in_shamt == '0) ? S_DONE : S_SHIFT;
                end else if (r_state == S_DONE && out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            S_SHIFT: begin
                w_data_next  = w_shift1;
                w_count_next = r_count - 1'b1;
                // The edge that takes count from 1 to 0 also performs the last shift.
                if (r_count == SHW'(1)) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_mode  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_data  <= w_data_next;
            r_mode  <= w_mode_next;
            r_count <= w_count_next;
        end
    end

endmodule
